// File: rtl/fft_twiddle_gen_pkg.sv
// Shared definitions for the radix-4 twiddle generator: FSM and quadrant
// codes, derived sizes, and the elaboration-time cos/sin table builders.
package fft_twiddle_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    // Top two exponent bits select which quarter of the unit circle we are in.
    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quad_e;

    localparam real TW_PI           = 3.14159265358979323846;
    localparam int  TW_TAYLOR_TERMS = 32'sd14;

    function automatic int clog2(input int value);
        int width;
        width = 32'sd0;
        while ((32'sd1 << width) < value) begin
            width = width + 32'sd1;
        end
        return width;
    endfunction

    // Fixed-point +1.0 for a signed twiddle of w_bit bits.
    function automatic int one_of(input int w_bit);
        return 32'sd1 << (w_bit - 32'sd2);
    endfunction

    // Number of radix-4 stages for an FFT of 2^log2_n points.
    function automatic int stages_of(input int log2_n);
        return log2_n / 32'sd2;
    endfunction

    // Taylor series; the argument never exceeds pi/2, so 14 terms are far
    // below one LSB of error and the rounded results are exact.
    function automatic real tw_sin_poly(input real x);
        real term;
        real sum;
        term = x;
        sum  = x;
        for (int n = 1; n < TW_TAYLOR_TERMS; n++) begin
            term = -term * x * x / ($itor(2 * n) * $itor(2 * n + 1));
            sum  = sum + term;
        end
        return sum;
    endfunction

    function automatic real tw_cos_poly(input real x);
        real term;
        real sum;
        term = 1.0;
        sum  = 1.0;
        for (int n = 1; n < TW_TAYLOR_TERMS; n++) begin
            term = -term * x * x / ($itor(2 * n - 1) * $itor(2 * n));
            sum  = sum + term;
        end
        return sum;
    endfunction

    // round(one * cos(2*pi*r/N)); always in 0..one for the first quadrant.
    function automatic int tw_rom_cos(input int r, input int log2_n, input int one);
        real x;
        x = 2.0 * TW_PI * $itor(r) / $itor(32'sd1 << log2_n);
        return $rtoi($itor(one) * tw_cos_poly(x) + 0.5);
    endfunction

    // round(one * sin(2*pi*r/N)); always in 0..one for the first quadrant.
    function automatic int tw_rom_sin(input int r, input int log2_n, input int one);
        real x;
        x = 2.0 * TW_PI * $itor(r) / $itor(32'sd1 << log2_n);
        return $rtoi($itor(one) * tw_sin_poly(x) + 0.5);
    endfunction

endpackage

// File: rtl/fft_twiddle_gen_rom.sv
// Quarter-wave cos/sin ROM: N/4 words of {cos,sin}, one read port,
// registered output that advances only with the stage enable.
// Contents are computed at elaboration as round(ONE*cos/sin(2*pi*r/N)).
module fft_twiddle_gen_rom
    import fft_twiddle_gen_pkg::*;
#(
    parameter int W_BIT  = 12,
    parameter int LOG2_N = 10
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [LOG2_N-3:0]       addr,
    output logic signed [W_BIT-1:0] cos_val,
    output logic signed [W_BIT-1:0] sin_val
);

    localparam int DEPTH = 32'sd1 << (LOG2_N - 2);
    localparam int ONE   = one_of(W_BIT);

    logic [2*W_BIT-1:0] rom_s [DEPTH];

    for (genvar r = 0; r < DEPTH; r++) begin : g_entry
        localparam int COS_V = tw_rom_cos(r, LOG2_N, ONE);
        localparam int SIN_V = tw_rom_sin(r, LOG2_N, ONE);
        assign rom_s[r] = {W_BIT'(COS_V), W_BIT'(SIN_V)};
    end

    // Synchronous read; holds the previous word while the pipe is frozen.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cos_val <= '0;
            sin_val <= '0;
        end else if (en) begin
            {cos_val, sin_val} <= rom_s[addr];
        end
    end

endmodule

// File: rtl/fft_twiddle_gen.sv
// Radix-4 twiddle source for one FFT stage: streams (W^k, W^2k, W^3k) per
// butterfly through a 3-deep pipe (exponent, ROM read, quadrant map).
// Optional feature macro FFT_TW_CONJ_EN adds iINV, which conjugates all
// twiddles of a sweep (IFFT direction) without adding latency.
module fft_twiddle_gen
    import fft_twiddle_gen_pkg::*;
#(
    parameter  int W_BIT   = 12,
    parameter  int LOG2_N  = 10,
    localparam int S       = stages_of(LOG2_N),
    localparam int STG_BIT = (S > 1) ? clog2(S) : 1
)(
    input  logic                    iCLK,
    input  logic                    iRESET,
    input  logic                    iSTART,
    input  logic [STG_BIT-1:0]      iSTAGE,
    input  logic                    iEN,
`ifdef FFT_TW_CONJ_EN
    input  logic                    iINV,
`endif
    output logic                    oBUSY,
    output logic                    oVALID,
    output logic                    oLAST,
    output logic signed [W_BIT-1:0] oW1_RE,
    output logic signed [W_BIT-1:0] oW1_IM,
    output logic signed [W_BIT-1:0] oW2_RE,
    output logic signed [W_BIT-1:0] oW2_IM,
    output logic signed [W_BIT-1:0] oW3_RE,
    output logic signed [W_BIT-1:0] oW3_IM
);

    localparam int                BF_BIT = LOG2_N - 2;
    localparam logic [BF_BIT-1:0] B_LAST = '1;

    // Sweep control
    state_e               state_r;
    logic [STG_BIT-1:0]   stage_r;
    logic [BF_BIT-1:0]    b_r;
    logic                 busy_r;
    logic                 inv_s;

    // Stage 1: exponents
    logic [BF_BIT-1:0]    k_s;
    logic [LOG2_N-1:0]    e_s [3];
    logic [LOG2_N-1:0]    e_r [3];
    logic                 v1_r;
    logic                 last1_r;

    // Stage 2: ROM words and their quadrants
    logic signed [W_BIT-1:0] rom_c [3];
    logic signed [W_BIT-1:0] rom_s [3];
    quad_e                q2_r [3];
    logic                 v2_r;
    logic                 last2_r;

    // Stage 3: mapped outputs
    logic signed [W_BIT-1:0] re_s [3];
    logic signed [W_BIT-1:0] im_raw_s [3];
    logic signed [W_BIT-1:0] im_s [3];
    logic signed [W_BIT-1:0] w_re_r [3];
    logic signed [W_BIT-1:0] w_im_r [3];

    logic issue_s;
    logic issue_last_s;

`ifdef FFT_TW_CONJ_EN
    logic inv_r;

    // Direction is fixed for a whole sweep, captured with the accepted start.
    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            inv_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && iSTART) begin
            inv_r <= iINV;
        end
    end

    assign inv_s = inv_r;
`else
    assign inv_s = 1'b0;
`endif

    // Sweep FSM: start is taken in IDLE even while iEN is low; everything
    // else advances only on iEN. Busy drops once the last triple is consumed.
    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            state_r <= ST_IDLE;
            stage_r <= '0;
            b_r     <= '0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (iSTART) begin
                        state_r <= ST_RUN;
                        stage_r <= iSTAGE;
                        b_r     <= '0;
                        busy_r  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (iEN) begin
                        b_r <= b_r + BF_BIT'(1'b1);
                        if (b_r == B_LAST) begin
                            state_r <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (iEN && oVALID && oLAST) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign oBUSY        = busy_r;
    assign issue_s      = (state_r == ST_RUN);
    assign issue_last_s = issue_s && (b_r == B_LAST);

    // Exponent k = (b << 2s) mod N/4; its multiples 2k and 3k stay below 3N/4.
    always_comb begin
        k_s    = b_r << {stage_r, 1'b0};
        e_s[0] = {2'b00, k_s};
        e_s[1] = {1'b0, k_s, 1'b0};
        e_s[2] = e_s[0] + e_s[1];
    end

    // Stage 1: register the three exponents with their valid/last tags.
    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            v1_r    <= 1'b0;
            last1_r <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                e_r[i] <= '0;
            end
        end else if (iEN) begin
            v1_r    <= issue_s;
            last1_r <= issue_last_s;
            for (int i = 0; i < 3; i++) begin
                e_r[i] <= e_s[i];
            end
        end
    end

    // Stage 2: one quarter-wave ROM per twiddle, addressed by the low exponent bits.
    for (genvar g = 0; g < 3; g++) begin : g_rom
        fft_twiddle_gen_rom #(
            .W_BIT  (W_BIT),
            .LOG2_N (LOG2_N)
        ) u_rom (
            .clk     (iCLK),
            .rst_n   (iRESET),
            .en      (iEN),
            .addr    (e_r[g][LOG2_N-3:0]),
            .cos_val (rom_c[g]),
            .sin_val (rom_s[g])
        );
    end

    // Stage 2: carry the quadrant and tags alongside the ROM read.
    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            v2_r    <= 1'b0;
            last2_r <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                q2_r[i] <= QUAD_0;
            end
        end else if (iEN) begin
            v2_r    <= v1_r;
            last2_r <= last1_r;
            for (int i = 0; i < 3; i++) begin
                q2_r[i] <= quad_e'(e_r[i][LOG2_N-1 -: 2]);
            end
        end
    end

    // Quadrant map from first-quadrant (c,s) to exp(-j*theta); IM optionally conjugated.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            re_s[i]     = '0;
            im_raw_s[i] = '0;
            case (q2_r[i])
                QUAD_0: begin
                    re_s[i]     = rom_c[i];
                    im_raw_s[i] = -rom_s[i];
                end
                QUAD_1: begin
                    re_s[i]     = -rom_s[i];
                    im_raw_s[i] = -rom_c[i];
                end
                QUAD_2: begin
                    re_s[i]     = -rom_c[i];
                    im_raw_s[i] = rom_s[i];
                end
                QUAD_3: begin
                    re_s[i]     = rom_s[i];
                    im_raw_s[i] = rom_c[i];
                end
                default: begin
                    re_s[i]     = rom_c[i];
                    im_raw_s[i] = -rom_s[i];
                end
            endcase
            im_s[i] = inv_s ? -im_raw_s[i] : im_raw_s[i];
        end
    end

    // Stage 3: registered outputs; frozen together with the tags when iEN is low.
    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            oVALID <= 1'b0;
            oLAST  <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                w_re_r[i] <= '0;
                w_im_r[i] <= '0;
            end
        end else if (iEN) begin
            oVALID <= v2_r;
            oLAST  <= last2_r;
            for (int i = 0; i < 3; i++) begin
                w_re_r[i] <= re_s[i];
                w_im_r[i] <= im_s[i];
            end
        end
    end

    assign oW1_RE = w_re_r[0];
    assign oW1_IM = w_im_r[0];
    assign oW2_RE = w_re_r[1];
    assign oW2_IM = w_im_r[1];
    assign oW3_RE = w_re_r[2];
    assign oW3_IM = w_im_r[2];

endmodule

// File: tb/tb_fft_twiddle_gen.sv
// Self-checking bench for fft_twiddle_gen (N=1024, W_BIT=12, ONE=1024).
// Every sweep is predicted as a queue of triples computed directly from
// exp(-j*2*pi*m*k/N); a negedge checker pops one triple per accepted oVALID.
module tb_fft_twiddle_gen;

    localparam int  W_BIT  = 12;
    localparam int  LOG2_N = 10;
    localparam int  N      = 1 << LOG2_N;
    localparam int  NBF    = N / 4;
    localparam real ONE    = 1024.0;
    localparam real PI     = 3.14159265358979323846;

    typedef struct packed {
        int re1; int im1;
        int re2; int im2;
        int re3; int im3;
        logic last;
    } trip_t;

    logic clk = 1'b0;
    logic iRESET, iSTART, iEN, inv;
    logic [2:0] iSTAGE;
    logic oBUSY, oVALID, oLAST;
    logic signed [W_BIT-1:0] oW1_RE, oW1_IM, oW2_RE, oW2_IM, oW3_RE, oW3_IM;

    int    n_tests = 0;
    int    n_fail  = 0;
    trip_t exp_q[$];
    trip_t t_chk;
    trip_t t_pin;
    int    sweep_cnt = 0;
    bit    idle_chk  = 1'b0;

    fft_twiddle_gen #(.W_BIT(W_BIT), .LOG2_N(LOG2_N)) dut (
        .iCLK   (clk),
        .iRESET (iRESET),
        .iSTART (iSTART),
        .iSTAGE (iSTAGE),
        .iEN    (iEN),
`ifdef FFT_TW_CONJ_EN
        .iINV   (inv),
`endif
        .oBUSY  (oBUSY),
        .oVALID (oVALID),
        .oLAST  (oLAST),
        .oW1_RE (oW1_RE),
        .oW1_IM (oW1_IM),
        .oW2_RE (oW2_RE),
        .oW2_IM (oW2_IM),
        .oW3_RE (oW3_RE),
        .oW3_IM (oW3_IM)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        else          return -$rtoi(0.5 - x);
    endfunction

    // Reference: twiddle m of butterfly b in stage s is exp(-/+j*2*pi*m*k/N),
    // k = j*4^s with j = b mod N/4^(s+1).
    function automatic trip_t model_trip(input int s, input int b, input bit conj);
        trip_t t;
        int    j, k;
        int    re[3], im[3];
        real   ang;
        j = b % (N >> (2 * (s + 1)));
        k = j * (1 << (2 * s));
        for (int m = 1; m <= 3; m++) begin
            ang       = 2.0 * PI * $itor(m * k) / $itor(N);
            re[m - 1] = rnd(ONE * $cos(ang));
            im[m - 1] = -rnd(ONE * $sin(ang));
            if (conj) im[m - 1] = -im[m - 1];
        end
        t.re1 = re[0]; t.im1 = im[0];
        t.re2 = re[1]; t.im2 = im[1];
        t.re3 = re[2]; t.im3 = im[2];
        t.last = (b == NBF - 1);
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_w(input string tag, input int r1, input int i1,
                           input int r2, input int i2, input int r3, input int i3);
        check({tag, "_valid"}, oVALID, 1);
        check({tag, "_w1re"}, int'(oW1_RE), r1);
        check({tag, "_w1im"}, int'(oW1_IM), i1);
        check({tag, "_w2re"}, int'(oW2_RE), r2);
        check({tag, "_w2im"}, int'(oW2_IM), i2);
        check({tag, "_w3re"}, int'(oW3_RE), r3);
        check({tag, "_w3im"}, int'(oW3_IM), i3);
    endtask

    // Pulse start (DUT must be idle) and enqueue the predicted sweep.
    task automatic start_sweep(input int s, input bit conj);
        iSTART = 1'b1;
        iSTAGE = 3'(s);
        inv    = conj;
        tick();
        iSTART = 1'b0;
        for (int b = 0; b < NBF; b++) exp_q.push_back(model_trip(s, b, conj));
    endtask

    // Run until oBUSY drops; optional random iEN and an ignored start while busy.
    task automatic wait_idle(input bit rand_en, input int budget);
        int n;
        n = 0;
        while (oBUSY === 1'b1 && n < budget) begin
            if (rand_en) iEN = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
            iSTART = (rand_en && n == 40) ? 1'b1 : 1'b0;
            iSTAGE = 3'd3;
            tick();
            n++;
        end
        iSTART = 1'b0;
        iEN    = 1'b1;
        check("idle_within_budget", oBUSY, 0);
    endtask

    // Compare process: one predicted triple per accepted output.
    always @(negedge clk) begin
        if (!iRESET) begin
            exp_q.delete();
            sweep_cnt = 0;
            idle_chk  = 1'b0;
        end else begin
            if (idle_chk) begin
                check("busy_fall_after_last", oBUSY, 0);
                idle_chk = 1'b0;
            end
            if (oVALID === 1'b1 && iEN === 1'b1) begin
                check("busy_during_valid", oBUSY, 1);
                if (exp_q.size() == 0) begin
                    check("spurious_valid", oVALID, 0);
                end else begin
                    t_chk = exp_q.pop_front();
                    sweep_cnt++;
                    check("w1_re", int'(oW1_RE), t_chk.re1);
                    check("w1_im", int'(oW1_IM), t_chk.im1);
                    check("w2_re", int'(oW2_RE), t_chk.re2);
                    check("w2_im", int'(oW2_IM), t_chk.im2);
                    check("w3_re", int'(oW3_RE), t_chk.re3);
                    check("w3_im", int'(oW3_IM), t_chk.im3);
                    check("last",  oLAST, t_chk.last);
                    if (t_chk.last) begin
                        check("sweep_len", sweep_cnt, NBF);
                        sweep_cnt = 0;
                        idle_chk  = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        iRESET = 1'b0; iSTART = 1'b0; iEN = 1'b1; inv = 1'b0; iSTAGE = 3'd0;

        // Pin the reference model with hand-computed values.
        t_pin = model_trip(0, 1, 1'b0);
        check("model_s0b1_w1", t_pin.re1 * 10000 + t_pin.im1, 1024 * 10000 - 6);
        check("model_s0b1_w2", t_pin.re2 * 10000 + t_pin.im2, 1024 * 10000 - 13);
        check("model_s0b1_w3", t_pin.re3 * 10000 + t_pin.im3, 1024 * 10000 - 19);
        t_pin = model_trip(0, 128, 1'b0);
        check("model_s0b128_w1re", t_pin.re1, 724);
        check("model_s0b128_w2im", t_pin.im2, -1024);
        check("model_s0b128_w3re", t_pin.re3, -724);
        t_pin = model_trip(1, 1, 1'b0);
        check("model_s1b1_w1im", t_pin.im1, -25);
        t_pin = model_trip(4, 255, 1'b0);
        check("model_s4_w3re", t_pin.re3, 1024);
        check("model_s4_last", t_pin.last, 1);

        // Reset state.
        repeat (3) tick();
        check("rst_busy", oBUSY, 0);
        check("rst_valid", oVALID, 0);
        check("rst_last", oLAST, 0);
        check("rst_w1re", int'(oW1_RE), 0);
        check("rst_w3im", int'(oW3_IM), 0);
        iRESET = 1'b1;
        tick();

        // 1/2: stage 0, latency and literal values at b=0, 1, 128.
        start_sweep(0, 1'b0);
        check("busy_after_start", oBUSY, 1);
        check("lat_c0", oVALID, 0);
        tick(); tick();
        check("lat_c2", oVALID, 0);
        tick();
        check_w("s0b0", 1024, 0, 1024, 0, 1024, 0);
        tick();
        check_w("s0b1", 1024, -6, 1024, -13, 1024, -19);
        repeat (127) tick();
        check_w("s0b128", 724, -724, 0, -1024, -724, -724);
        wait_idle(1'b0, 2000);

        // 3: stage 4, all twiddles trivial; last/busy checked by the compare process.
        start_sweep(4, 1'b0);
        wait_idle(1'b0, 2000);

        // 4: stage 1 with random stalls and an ignored start while busy.
        start_sweep(1, 1'b0);
        wait_idle(1'b1, 5000);
        repeat (6) tick();
        check("no_restart_after_ignored_start", oBUSY, 0);
        check("queue_empty_s1", exp_q.size(), 0);

        // 5: reset at b=100 aborts, then a start with iEN low is still taken.
        start_sweep(2, 1'b0);
        repeat (100) tick();
        iRESET = 1'b0;
        tick();
        check("abort_busy", oBUSY, 0);
        check("abort_valid", oVALID, 0);
        check("abort_last", oLAST, 0);
        check("abort_w1re", int'(oW1_RE), 0);
        check("abort_w2im", int'(oW2_IM), 0);
        check("abort_w3re", int'(oW3_RE), 0);
        iRESET = 1'b1;
        tick();
        iEN = 1'b0;
        start_sweep(2, 1'b0);
        repeat (4) tick();
        check("start_with_en_low", oBUSY, 1);
        check("frozen_no_valid", oVALID, 0);
        iEN = 1'b1;
        wait_idle(1'b0, 2000);

        // Extra randomized sweeps.
        for (int r = 0; r < 2; r++) begin
            start_sweep($urandom_range(0, 4), 1'b0);
            wait_idle(1'b1, 5000);
        end

`ifdef FFT_TW_CONJ_EN
        // 6: conjugated twiddles.
        start_sweep(0, 1'b1);
        repeat (3 + 128) tick();
        check_w("inv_s0b128", 724, 724, 0, 1024, -724, 724);
        wait_idle(1'b0, 2000);
        inv = 1'b0;
`endif

        repeat (5) tick();
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
